execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 169 ++++++++++++++++
 tb/tb_execute_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: D/E register, ALU, memory-operand steering and E/M register.
// Optional EXEC_MUL_EN makes ALUop 111 a multiply; otherwise it passes srcB.
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int RDST_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              wbs_in,
    input  logic              wm_in,
    input  logic              am_in,
    input  logic              ni_in,
    input  logic              wce_in,
    input  logic              wme1_in,
    input  logic              wme2_in,
    input  logic              alu_mux_in,
    input  logic              reg_dest_in,
    input  logic              wre_in,
    input  logic [1:0]        mm_in,
    input  logic [2:0]        ALUop_in,
    input  logic [RDST_W-1:0] reg_dest_data_in,
    input  logic [DATA_W-1:0] srcA_in,
    input  logic [DATA_W-1:0] srcB_in,
    output logic              wbs_out,
    output logic              wm_out,
    output logic              ni_out,
    output logic              wce_out,
    output logic              wme1_out,
    output logic              wme2_out,
    output logic              reg_dest_out,
    output logic              wre_out,
    output logic [1:0]        mm_out,
    output logic [RDST_W-1:0] reg_dest_data_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic [DATA_W-1:0] memData_out,
    output logic              flagN,
    output logic              flagZ
);

    typedef struct packed {
        logic              wbs;
        logic              wm;
        logic              am;
        logic              ni;
        logic              wce;
        logic              wme1;
        logic              wme2;
        logic              alu_mux;
        logic              reg_dest;
        logic              wre;
        logic [1:0]        mm;
        logic [2:0]        aluop;
        logic [RDST_W-1:0] rdd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } de_t;

    typedef struct packed {
        logic              wbs;
        logic              wm;
        logic              ni;
        logic              wce;
        logic              wme1;
        logic              wme2;
        logic              reg_dest;
        logic              wre;
        logic [1:0]        mm;
        logic [RDST_W-1:0] rdd;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] mem;
    } em_t;

    de_t de_d, de_q;
    em_t em_d, em_q;

    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] addr_or_data;
    logic [DATA_W-1:0] store_data;

    always_comb begin
        de_d.wbs      = wbs_in;
        de_d.wm       = wm_in;
        de_d.am       = am_in;
        de_d.ni       = ni_in;
        de_d.wce      = wce_in;
        de_d.wme1     = wme1_in;
        de_d.wme2     = wme2_in;
        de_d.alu_mux  = alu_mux_in;
        de_d.reg_dest = reg_dest_in;
        de_d.wre      = wre_in;
        de_d.mm       = mm_in;
        de_d.aluop    = ALUop_in;
        de_d.rdd      = reg_dest_data_in;
        de_d.a        = srcA_in;
        de_d.b        = srcB_in;
    end

    always_comb begin
        alu = '0;
        unique case (de_q.aluop)
            3'b000: alu = de_q.a + de_q.b;
            3'b001: alu = de_q.a - de_q.b;
            3'b010: alu = de_q.a & de_q.b;
            3'b011: alu = de_q.a | de_q.b;
            3'b100: alu = de_q.a ^ de_q.b;
            3'b101: alu = de_q.a << de_q.b[3:0];
            3'b110: alu = de_q.a >> de_q.b[3:0];
`ifdef EXEC_MUL_EN
            3'b111: alu = de_q.a * de_q.b;
`else
            3'b111: alu = de_q.b;
`endif
        endcase
    end

    assign flagN = alu[DATA_W-1];
    assign flagZ = (alu == '0);

    // am selects whether srcB is an address/data operand or store data
    assign addr_or_data = de_q.am ? '0 : de_q.b;
    assign store_data   = de_q.am ? de_q.b : '0;

    always_comb begin
        em_d.wbs      = de_q.wbs;
        em_d.wm       = de_q.wm;
        em_d.ni       = de_q.ni;
        em_d.wce      = de_q.wce;
        em_d.wme1     = de_q.wme1;
        em_d.wme2     = de_q.wme2;
        em_d.reg_dest = de_q.reg_dest;
        em_d.wre      = de_q.wre;
        em_d.mm       = de_q.mm;
        em_d.rdd      = de_q.rdd;
        em_d.res      = de_q.alu_mux ? addr_or_data : alu;
        em_d.mem      = store_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            de_q <= '0;
        else if (flush)
            de_q <= '0;
        else if (!stall)
            de_q <= de_d;
    end

    always_ff @(posedge clk) begin
        if (reset)
            em_q <= '0;
        else if (!stall)
            em_q <= em_d;
    end

    assign wbs_out           = em_q.wbs;
    assign wm_out            = em_q.wm;
    assign ni_out            = em_q.ni;
    assign wce_out           = em_q.wce;
    assign wme1_out          = em_q.wme1;
    assign wme2_out          = em_q.wme2;
    assign reg_dest_out      = em_q.reg_dest;
    assign wre_out           = em_q.wre;
    assign mm_out            = em_q.mm;
    assign reg_dest_data_out = em_q.rdd;
    assign ALUresult_out     = em_q.res;
    assign memData_out       = em_q.mem;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table plus
// stall, flush and reset sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        wbs_in, wm_in, am_in, ni_in, wce_in, wme1_in, wme2_in;
    logic        alu_mux_in, reg_dest_in, wre_in;
    logic [1:0]  mm_in;
    logic [2:0]  ALUop_in;
    logic [3:0]  reg_dest_data_in;
    logic [15:0] srcA_in, srcB_in;
    logic        wbs_out, wm_out, ni_out, wce_out, wme1_out, wme2_out;
    logic        reg_dest_out, wre_out;
    logic [1:0]  mm_out;
    logic [3:0]  reg_dest_data_out;
    logic [15:0] ALUresult_out, memData_out;
    logic        flagN, flagZ;

    int checks = 0;
    int errors = 0;

    execute_stage #(.DATA_W(16), .RDST_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .wbs_in(wbs_in), .wm_in(wm_in), .am_in(am_in), .ni_in(ni_in),
        .wce_in(wce_in), .wme1_in(wme1_in), .wme2_in(wme2_in),
        .alu_mux_in(alu_mux_in), .reg_dest_in(reg_dest_in),
        .wre_in(wre_in), .mm_in(mm_in), .ALUop_in(ALUop_in),
        .reg_dest_data_in(reg_dest_data_in),
        .srcA_in(srcA_in), .srcB_in(srcB_in),
        .wbs_out(wbs_out), .wm_out(wm_out), .ni_out(ni_out),
        .wce_out(wce_out), .wme1_out(wme1_out), .wme2_out(wme2_out),
        .reg_dest_out(reg_dest_out), .wre_out(wre_out),
        .mm_out(mm_out), .reg_dest_data_out(reg_dest_data_out),
        .ALUresult_out(ALUresult_out), .memData_out(memData_out),
        .flagN(flagN), .flagZ(flagZ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        am;
        logic        amux;
        logic [7:0]  ctrl;
        logic [1:0]  mm;
        logic [3:0]  rdd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] mem;
        logic        n;
        logic        z;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ctrl = {wbs,wm,ni,wce,wme1,wme2,reg_dest,wre}
    task automatic drive(input logic [2:0] op, input logic am,
                         input logic amux, input logic [7:0] ctrl,
                         input logic [1:0] mm, input logic [3:0] rdd,
                         input logic [15:0] a, input logic [15:0] b);
        ALUop_in = op;
        am_in = am;
        alu_mux_in = amux;
        {wbs_in, wm_in, ni_in, wce_in, wme1_in, wme2_in,
         reg_dest_in, wre_in} = ctrl;
        mm_in = mm;
        reg_dest_data_in = rdd;
        srcA_in = a;
        srcB_in = b;
    endtask

    task automatic idle();
        drive(3'd0, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0, 16'h0, 16'h0);
    endtask

    task automatic add(input logic [15:0] a, input logic [15:0] b,
                       input logic wre, input logic [3:0] rdd);
        drive(3'd0, 1'b0, 1'b0, {7'b0, wre}, 2'd0, rdd, a, b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctrl_out();
        return {wbs_out, wm_out, ni_out, wce_out, wme1_out, wme2_out,
                reg_dest_out, wre_out};
    endfunction

    initial begin
        logic [15:0] mul_exp;
`ifdef EXEC_MUL_EN
        mul_exp = 16'd12;
`else
        mul_exp = 16'd4;
`endif
        vt[0]  = '{3'd1, 0, 0, 8'h01, 2'd1, 4'd1,
                   16'd5, 16'd7, 16'hFFFE, 16'h0, 1, 0};
        vt[1]  = '{3'd0, 0, 0, 8'h80, 2'd2, 4'd2,
                   16'hFFFF, 16'h1, 16'h0000, 16'h0, 0, 1};
        vt[2]  = '{3'd5, 0, 0, 8'h40, 2'd3, 4'd3,
                   16'h1, 16'h0013, 16'h0008, 16'h0, 0, 0};
        vt[3]  = '{3'd6, 0, 0, 8'h20, 2'd0, 4'd4,
                   16'h8000, 16'h4, 16'h0800, 16'h0, 0, 0};
        vt[4]  = '{3'd2, 0, 0, 8'h10, 2'd1, 4'd5,
                   16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 0, 0};
        vt[5]  = '{3'd3, 0, 0, 8'h04, 2'd2, 4'd6,
                   16'hF000, 16'h000F, 16'hF00F, 16'h0, 1, 0};
        vt[6]  = '{3'd4, 0, 0, 8'h02, 2'd3, 4'd7,
                   16'hFFFF, 16'h00FF, 16'hFF00, 16'h0, 1, 0};
        vt[7]  = '{3'd7, 0, 0, 8'h00, 2'd0, 4'd8,
                   16'd3, 16'd4, mul_exp, 16'h0, 0, 0};
        vt[8]  = '{3'd0, 1, 1, 8'h08, 2'd1, 4'd9,
                   16'h0, 16'h1234, 16'h0000, 16'h1234, 0, 0};
        vt[9]  = '{3'd0, 0, 1, 8'hFF, 2'd2, 4'hA,
                   16'h1, 16'h1234, 16'h1234, 16'h0, 0, 0};
        vt[10] = '{3'd0, 1, 0, 8'hAA, 2'd3, 4'hB,
                   16'd2, 16'd3, 16'd5, 16'd3, 0, 0};
        vt[11] = '{3'd6, 0, 0, 8'h55, 2'd0, 4'hF,
                   16'hFFFF, 16'h0010, 16'hFFFF, 16'h0, 1, 0};
        vt[12] = '{3'd1, 0, 0, 8'h01, 2'd1, 4'hC,
                   16'd7, 16'd7, 16'h0000, 16'h0, 0, 1};

        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(3'd1, 1'b1, 1'b1, 8'hFF, 2'd3, 4'hF, 16'hAAAA, 16'h5555);
        step();
        step();
        chk("rst_res", ALUresult_out, 16'h0);
        chk("rst_mem", memData_out, 16'h0);
        chk("rst_ctrl", ctrl_out(), 8'h00);
        chk("rst_mm", mm_out, 2'd0);
        chk("rst_rdd", reg_dest_data_out, 4'd0);
        chk("rst_n", flagN, 1'b0);
        chk("rst_z", flagZ, 1'b1);
        reset = 1'b0;
        idle();

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].op, vt[i].am, vt[i].amux, vt[i].ctrl,
                  vt[i].mm, vt[i].rdd, vt[i].a, vt[i].b);
            step();
            chk($sformatf("v%0d_n", i), flagN, vt[i].n);
            chk($sformatf("v%0d_z", i), flagZ, vt[i].z);
            step();
            chk($sformatf("v%0d_res", i), ALUresult_out, vt[i].res);
            chk($sformatf("v%0d_mem", i), memData_out, vt[i].mem);
            chk($sformatf("v%0d_ctrl", i), ctrl_out(), vt[i].ctrl);
            chk($sformatf("v%0d_mm", i), mm_out, vt[i].mm);
            chk($sformatf("v%0d_rdd", i), reg_dest_data_out, vt[i].rdd);
        end

        // stall for three cycles in the middle of a stream
        add(16'd0, 16'd100, 1'b1, 4'd0);
        step();
        add(16'd1, 16'd100, 1'b1, 4'd1);
        step();
        chk("st_i0", ALUresult_out, 16'd100);
        add(16'd2, 16'd100, 1'b1, 4'd2);
        step();
        chk("st_i1", ALUresult_out, 16'd101);
        stall = 1'b1;
        add(16'd3, 16'd100, 1'b1, 4'd3);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("st_hold%0d", c), ALUresult_out, 16'd101);
            chk($sformatf("st_hrdd%0d", c), reg_dest_data_out, 4'd1);
            chk($sformatf("st_hz%0d", c), flagZ, 1'b0);
        end
        stall = 1'b0;
        step();
        chk("st_i2", ALUresult_out, 16'd102);
        add(16'd4, 16'd100, 1'b1, 4'd4);
        step();
        chk("st_i3", ALUresult_out, 16'd103);
        idle();
        step();
        chk("st_i4", ALUresult_out, 16'd104);
        chk("st_i4rdd", reg_dest_data_out, 4'd4);
        step();
        chk("st_bub", ALUresult_out, 16'd0);

        // flush alone: D/E bubbled, E/M still takes the older op
        add(16'd2, 16'd2, 1'b1, 4'd5);
        step();
        add(16'd1, 16'd1, 1'b1, 4'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_prev", ALUresult_out, 16'd4);
        chk("fl_prevwre", wre_out, 1'b1);
        chk("fl_z", flagZ, 1'b1);
        idle();
        step();
        chk("fl_wre", wre_out, 1'b0);
        chk("fl_res", ALUresult_out, 16'd0);

        // flush with stall: D/E cleared, E/M holds
        add(16'd3, 16'd3, 1'b1, 4'd7);
        step();
        add(16'd4, 16'd4, 1'b1, 4'd8);
        step();
        chk("fs_k2", ALUresult_out, 16'd6);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        chk("fs_hold", ALUresult_out, 16'd6);
        chk("fs_z", flagZ, 1'b1);
        idle();
        step();
        chk("fs_res", ALUresult_out, 16'd0);
        chk("fs_wre", wre_out, 1'b0);

        // reset in flight discards both stages
        add(16'h0010, 16'h0001, 1'b1, 4'd9);
        step();
        add(16'h0020, 16'h0001, 1'b1, 4'hA);
        step();
        chk("mr_pre", ALUresult_out, 16'h0011);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        chk("mr_res", ALUresult_out, 16'h0);
        chk("mr_wre", wre_out, 1'b0);
        chk("mr_z", flagZ, 1'b1);
        step();
        chk("mr_res2", ALUresult_out, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
